// File: rtl/snake_body_ring_if.sv
// Bus between the snake body ring and its clients: update/tail signals for the
// game FSM, streaming read-out for the renderer, and the collision-check engine.
// The slave modport is the ring itself; the master modport is the client side.
interface snake_body_ring_if #(
  parameter int COORD_W = 11,
  parameter int DEPTH   = 32
);
  localparam int PTR_W = $clog2(DEPTH);

  // Body updates
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               grow;
  logic               move;
  logic [PTR_W:0]     len;
  logic               full;
  logic [COORD_W-1:0] tail_x;
  logic [COORD_W-1:0] tail_y;

  // Read-out scan
  logic               rd_start;
  logic               rd_valid;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               rd_last;

  // Collision check
  logic               chk_start;
  logic [COORD_W-1:0] chk_x;
  logic [COORD_W-1:0] chk_y;
  logic               chk_busy;
  logic               chk_done;
  logic               chk_hit;
  logic               self_hit;

  modport slave (
    input  head_x, head_y, grow, move, rd_start, chk_start, chk_x, chk_y,
    output len, full, tail_x, tail_y, rd_valid, rd_x, rd_y, rd_last,
           chk_busy, chk_done, chk_hit, self_hit
  );

  modport master (
    output head_x, head_y, grow, move, rd_start, chk_start, chk_x, chk_y,
    input  len, full, tail_x, tail_y, rd_valid, rd_x, rd_y, rd_last,
           chk_busy, chk_done, chk_hit, self_hit
  );
endinterface

// File: rtl/snake_body_ring.sv
// Snake body ring buffer: holds segment coordinates oldest (tail) to newest
// (head), supports grow/move updates, a streaming read-out for the renderer
// and a sequential collision-check engine for the game FSM.
// Optional parallel self-collision detector: define SNAKE_BODY_SELF_HIT_EN.
module snake_body_ring #(
  parameter  int COORD_W = 11,
  parameter  int DEPTH   = 32,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  snake_body_ring_if.slave    bus
);

  localparam logic [PTR_W:0] LEN_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LEN_ONE  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {CHK_IDLE, CHK_SCAN, CHK_DONE} chk_state_t;

  // Storage (no reset: every read is qualified by len)
  logic [COORD_W-1:0] mem_x_q [DEPTH];
  logic [COORD_W-1:0] mem_y_q [DEPTH];

  // Ring control
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   tail_ptr_q, tail_ptr_d;
  logic [PTR_W:0]     len_q, len_d;
  logic [COORD_W-1:0] tail_x_q, tail_x_d;
  logic [COORD_W-1:0] tail_y_q, tail_y_d;
  logic               wr_en, grow_eff, shift_en, full_w;

  // Read-out scan
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     rd_rem_q, rd_rem_d;

  // Collision check
  chk_state_t         chk_state_q, chk_state_d;
  logic [COORD_W-1:0] chk_qx_q, chk_qx_d;
  logic [COORD_W-1:0] chk_qy_q, chk_qy_d;
  logic [PTR_W-1:0]   chk_ptr_q, chk_ptr_d;
  logic [PTR_W:0]     chk_rem_q, chk_rem_d;
  logic               chk_hit_q, chk_hit_d;

  // Reset synchroniser: assertion is immediate, release is aligned to clk
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_i;

  // Shift ones into the synchroniser once reset_n is released
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Synchroniser register, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_i = rst_sync_q[1];

  // A full grow degrades to a move; a move on an empty body degrades to a grow
  assign full_w   = (len_q == LEN_FULL);
  assign wr_en    = bus.grow | bus.move;
  assign grow_eff = wr_en && !full_w && (bus.grow || (len_q == '0));
  assign shift_en = wr_en && !grow_eff;

  // Next-state for ring pointers, length and the registered tail coordinate
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    tail_ptr_d = tail_ptr_q;
    len_d      = len_q;
    tail_x_d   = '0;
    tail_y_d   = '0;
    if (wr_en)    wr_ptr_d   = wr_ptr_q + 1'b1;
    if (shift_en) tail_ptr_d = tail_ptr_q + 1'b1;
    if (grow_eff) len_d      = len_q + 1'b1;
    if (len_d != '0) begin
      // The new tail may be the slot written this very cycle (first grow)
      if (wr_en && (tail_ptr_d == wr_ptr_q)) begin
        tail_x_d = bus.head_x;
        tail_y_d = bus.head_y;
      end else begin
        tail_x_d = mem_x_q[tail_ptr_d];
        tail_y_d = mem_y_q[tail_ptr_d];
      end
    end
  end

  // Next-state for the read-out scan; rd_start (re)latches tail and length
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    rd_rem_d = rd_rem_q;
    if (bus.rd_start) begin
      rd_ptr_d = tail_ptr_q;
      rd_rem_d = len_q;
    end else if (rd_rem_q != '0) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rd_rem_d = rd_rem_q - 1'b1;
    end
  end

  // Collision-check FSM: walk tail toward head, newest entry excluded
  always_comb begin
    chk_state_d = chk_state_q;
    chk_qx_d    = chk_qx_q;
    chk_qy_d    = chk_qy_q;
    chk_ptr_d   = chk_ptr_q;
    chk_rem_d   = chk_rem_q;
    chk_hit_d   = chk_hit_q;
    case (chk_state_q)
      CHK_IDLE: begin
        if (bus.chk_start) begin
          chk_qx_d  = bus.chk_x;
          chk_qy_d  = bus.chk_y;
          chk_ptr_d = tail_ptr_q;
          chk_hit_d = 1'b0;
          if (len_q > LEN_ONE) begin
            chk_rem_d   = len_q - 1'b1;
            chk_state_d = CHK_SCAN;
          end else begin
            chk_rem_d   = '0;
            chk_state_d = CHK_DONE;
          end
        end
      end
      CHK_SCAN: begin
        if ((mem_x_q[chk_ptr_q] == chk_qx_q) && (mem_y_q[chk_ptr_q] == chk_qy_q)) begin
          chk_hit_d   = 1'b1;
          chk_state_d = CHK_DONE;
        end else if (chk_rem_q == LEN_ONE) begin
          chk_state_d = CHK_DONE;
        end else begin
          chk_ptr_d = chk_ptr_q + 1'b1;
          chk_rem_d = chk_rem_q - 1'b1;
        end
      end
      CHK_DONE: chk_state_d = CHK_IDLE;
      default:  chk_state_d = CHK_IDLE;
    endcase
  end

  // Control registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      tail_ptr_q  <= '0;
      len_q       <= '0;
      tail_x_q    <= '0;
      tail_y_q    <= '0;
      rd_ptr_q    <= '0;
      rd_rem_q    <= '0;
      chk_state_q <= CHK_IDLE;
      chk_ptr_q   <= '0;
      chk_rem_q   <= '0;
      chk_hit_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      tail_ptr_q  <= tail_ptr_d;
      len_q       <= len_d;
      tail_x_q    <= tail_x_d;
      tail_y_q    <= tail_y_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_rem_q    <= rd_rem_d;
      chk_state_q <= chk_state_d;
      chk_ptr_q   <= chk_ptr_d;
      chk_rem_q   <= chk_rem_d;
      chk_hit_q   <= chk_hit_d;
    end
  end

  // Data registers: segment storage and the latched query coordinate
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x_q[wr_ptr_q] <= bus.head_x;
      mem_y_q[wr_ptr_q] <= bus.head_y;
    end
    chk_qx_q <= chk_qx_d;
    chk_qy_q <= chk_qy_d;
  end

`ifdef SNAKE_BODY_SELF_HIT_EN
  logic             self_hit_q, self_hit_d;
  logic [PTR_W-1:0] sh_off;

  // Compare the incoming head against every live entry except a dropped tail
  always_comb begin
    self_hit_d = self_hit_q;
    sh_off     = '0;
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        sh_off = PTR_W'(i) - tail_ptr_q;
        if (({1'b0, sh_off} < len_q) && !(shift_en && (sh_off == '0)) &&
            (mem_x_q[PTR_W'(i)] == bus.head_x) && (mem_y_q[PTR_W'(i)] == bus.head_y))
          self_hit_d = 1'b1;
      end
    end
  end

  // Sticky self-collision flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) self_hit_q <= 1'b0;
    else          self_hit_q <= self_hit_d;
  end

  assign bus.self_hit = self_hit_q;
`else
  assign bus.self_hit = 1'b0;
`endif

  assign bus.len      = len_q;
  assign bus.full     = full_w;
  assign bus.tail_x   = tail_x_q;
  assign bus.tail_y   = tail_y_q;
  assign bus.rd_valid = (rd_rem_q != '0);
  assign bus.rd_last  = (rd_rem_q == LEN_ONE);
  assign bus.rd_x     = bus.rd_valid ? mem_x_q[rd_ptr_q] : '0;
  assign bus.rd_y     = bus.rd_valid ? mem_y_q[rd_ptr_q] : '0;
  assign bus.chk_busy = (chk_state_q != CHK_IDLE);
  assign bus.chk_done = (chk_state_q == CHK_DONE);
  assign bus.chk_hit  = chk_hit_q;

endmodule

// File: tb/tb_snake_body_ring.sv
// Scoreboard bench for snake_body_ring: stimulus tasks push expected read-out
// entries and check results into queues; a monitor pops and compares them
// whenever the ring presents rd_valid or chk_done.
module tb_snake_body_ring;
  localparam int COORD_W = 11;
  localparam int DEPTH   = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  snake_body_ring_if #(.COORD_W(COORD_W), .DEPTH(DEPTH)) bus ();

  snake_body_ring #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;
  } rd_t;

  int   checks = 0;
  int   errors = 0;
  rd_t  rd_exp[$];
  logic chk_exp[$];
  int   mx[$];
  int   my[$];
  logic exp_self = 1'b0;
  rd_t  mon_e;
  logic mon_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=output_present expected=none", name);
  endtask

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rd_valid) begin
        if (rd_exp.size() == 0) unexpected("rd_unexpected");
        else begin
          mon_e = rd_exp.pop_front();
          check("rd_x", 32'(bus.rd_x), 32'(mon_e.x));
          check("rd_y", 32'(bus.rd_y), 32'(mon_e.y));
          check("rd_last", 32'(bus.rd_last), 32'(mon_e.last));
        end
      end
      if (bus.chk_done) begin
        if (chk_exp.size() == 0) unexpected("chk_unexpected");
        else begin
          mon_h = chk_exp.pop_front();
          check("chk_hit", 32'(bus.chk_hit), 32'(mon_h));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of a grow (is_grow=1) or move request
  task automatic m_write(input int x, input int y, input bit is_grow);
    bit do_grow;
    do_grow = is_grow ? (mx.size() < DEPTH) : (mx.size() == 0);
`ifdef SNAKE_BODY_SELF_HIT_EN
    for (int k = (do_grow ? 0 : 1); k < mx.size(); k++)
      if (mx[k] == x && my[k] == y) exp_self = 1'b1;
`endif
    if (!do_grow) begin
      void'(mx.pop_front());
      void'(my.pop_front());
    end
    mx.push_back(x);
    my.push_back(y);
  endtask

  task automatic update(input int x, input int y, input bit g, input bit m);
    bus.head_x = COORD_W'(x);
    bus.head_y = COORD_W'(y);
    bus.grow   = g;
    bus.move   = m;
    m_write(x, y, g);
    tick();
    bus.grow = 1'b0;
    bus.move = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((rd_exp.size() != 0 || chk_exp.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (rd_exp.size() != 0 || chk_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending expected=0", rd_exp.size(), chk_exp.size());
      rd_exp.delete();
      chk_exp.delete();
    end
  endtask

  task automatic scan();
    rd_t e;
    for (int k = 0; k < mx.size(); k++) begin
      e.x = COORD_W'(mx[k]);
      e.y = COORD_W'(my[k]);
      e.last = (k == mx.size() - 1);
      rd_exp.push_back(e);
    end
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    drain(DEPTH + 5);
  endtask

  task automatic chk(input int x, input int y);
    logic hit = 1'b0;
    int   lim;
    int   cycles = 0;
    for (int k = 0; k < mx.size() - 1; k++)
      if (mx[k] == x && my[k] == y) hit = 1'b1;
    lim = (mx.size() < 1) ? 1 : mx.size();
    chk_exp.push_back(hit);
    bus.chk_x = COORD_W'(x);
    bus.chk_y = COORD_W'(y);
    bus.chk_start = 1'b1;
    tick();
    bus.chk_start = 1'b0;
    while (!bus.chk_done && cycles < DEPTH + 4) begin
      tick();
      cycles++;
    end
    check("chk_latency_ok", 32'(cycles <= lim), 32'd1);
    drain(4);
    tick();
    check("chk_hit_hold", 32'(bus.chk_hit), 32'(hit));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.grow = 1'b0; bus.move = 1'b0; bus.rd_start = 1'b0; bus.chk_start = 1'b0;
    repeat (2) tick();
    rd_exp.delete();
    chk_exp.delete();
    mx.delete();
    my.delete();
    exp_self = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.head_x = '0; bus.head_y = '0; bus.grow = 1'b0; bus.move = 1'b0;
    bus.rd_start = 1'b0; bus.chk_start = 1'b0; bus.chk_x = '0; bus.chk_y = '0;

    // Reset state
    repeat (3) tick();
    check("rst_len", 32'(bus.len), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_tail_x", 32'(bus.tail_x), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_chk_busy", 32'(bus.chk_busy), 0);
    check("rst_chk_hit", 32'(bus.chk_hit), 0);
    check("rst_self_hit", 32'(bus.self_hit), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Grow three segments and read them out
    update(5, 5, 1, 0);
    update(6, 5, 1, 0);
    update(7, 5, 1, 0);
    check("len3", 32'(bus.len), 3);
    check("tail3_x", 32'(bus.tail_x), 5);
    check("tail3_y", 32'(bus.tail_y), 5);
    scan();

    // Move, then collision checks (tail hit, head excluded)
    update(8, 5, 0, 1);
    check("move_len", 32'(bus.len), 3);
    check("move_tail_x", 32'(bus.tail_x), 6);
    check("move_tail_y", 32'(bus.tail_y), 5);
    chk(6, 5);
    chk(8, 5);
    chk(7, 5);
    scan();

    // grow+move together at len=2, then chk_start while busy is ignored
    do_reset();
    update(1, 1, 1, 0);
    update(2, 1, 1, 0);
    update(3, 1, 1, 1);
    check("both_len", 32'(bus.len), 3);
    check("both_tail_x", 32'(bus.tail_x), 1);
    chk_exp.push_back(1'b0);
    bus.chk_x = COORD_W'(50); bus.chk_y = COORD_W'(50);
    bus.chk_start = 1'b1;
    tick();
    check("busy_after_start", 32'(bus.chk_busy), 1);
    bus.chk_x = COORD_W'(1); bus.chk_y = COORD_W'(1);
    tick();
    bus.chk_start = 1'b0;
    drain(8);
    repeat (6) tick();
    check("busy_ignored_hit", 32'(bus.chk_hit), 0);

    // Empty ring: read-out yields nothing, check completes with no hit
    do_reset();
    scan();
    repeat (4) tick();
    chk(9, 9);

    // Fill to DEPTH, overflow grow acts as move
    do_reset();
    for (int i = 0; i < DEPTH; i++) update(i + 10, i + 300, 1, 0);
    check("fill_len", 32'(bus.len), DEPTH);
    check("fill_full", 32'(bus.full), 1);
    check("fill_tail_x", 32'(bus.tail_x), 10);
    update(100, 100, 1, 0);
    check("ovf_len", 32'(bus.len), DEPTH);
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_tail_x", 32'(bus.tail_x), 11);
    check("ovf_tail_y", 32'(bus.tail_y), 301);
    scan();
    chk(40, 330);

    // Reset asserted mid-scan and mid-check
    for (int k = 0; k < 3; k++) begin
      mon_e.x = COORD_W'(mx[k]);
      mon_e.y = COORD_W'(my[k]);
      mon_e.last = 1'b0;
      rd_exp.push_back(mon_e);
    end
    bus.chk_x = COORD_W'(2000); bus.chk_y = COORD_W'(2000);
    bus.rd_start = 1'b1; bus.chk_start = 1'b1;
    tick();
    bus.rd_start = 1'b0; bus.chk_start = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("abort_rd_valid", 32'(bus.rd_valid), 0);
    check("abort_rd_x", 32'(bus.rd_x), 0);
    check("abort_chk_busy", 32'(bus.chk_busy), 0);
    check("abort_len", 32'(bus.len), 0);
    check("abort_full", 32'(bus.full), 0);
    check("abort_tail_x", 32'(bus.tail_x), 0);
    check("abort_rd_pending", 32'(rd_exp.size()), 0);
    rd_exp.delete();
    chk_exp.delete();
    mx.delete();
    my.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (40) tick();
    check("abort_chk_done", 32'(bus.chk_done), 0);

    // Self collision: move head onto a non-tail segment
    do_reset();
    update(1, 1, 1, 0);
    update(2, 1, 1, 0);
    update(3, 1, 1, 0);
    update(4, 1, 1, 0);
    check("self_before", 32'(bus.self_hit), 32'(exp_self));
    update(2, 1, 0, 1);
    check("self_after", 32'(bus.self_hit), 32'(exp_self));
    repeat (3) tick();
    check("self_sticky", 32'(bus.self_hit), 32'(exp_self));
`ifdef SNAKE_BODY_SELF_HIT_EN
    check("self_expected_set", 32'(bus.self_hit), 1);
`else
    check("self_expected_clear", 32'(bus.self_hit), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
